// File: rtl/ltm_frame_capture.sv
// LTM panel stream receiver: rebuilds pixel X/Y from HD/VD/DEN, converts each
// pixel to 8-bit luma and issues one frame-buffer write per active pixel.
// One frame is captured per i_start.
module ltm_frame_capture #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter bit          FLIP_Y   = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_HD,
   input  logic       i_VD,
   input  logic       i_DEN,
   input  logic [7:0] i_R,
   input  logic [7:0] i_G,
   input  logic [7:0] i_B,
   output logic       o_we,
   output logic [9:0] o_addrX,
   output logic [8:0] o_addrY,
   output logic [7:0] o_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   localparam int unsigned XW = 10;
   localparam int unsigned YW = 9;
   localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t state, state_nx;

   // stage 1: registered inputs
   logic       hd1, vd1, den1;
   logic [7:0] r1, g1, b1;
   // stage 2: one pixel with its edge flags and luma
   logic       hd2, vd2, den2;
   logic       hd_fall, vd_fall, den_fall;
   logic [7:0] luma2;
   logic [9:0] sum1;

   // counters and next values
   logic [XW-1:0] x, x_nx, x_eff;
   logic [YW-1:0] line, line_nx, line_eff;
   logic          last_wr, last_nx;
   logic          capturing;
   logic          we_nx, err_nx;
   logic [XW-1:0] addr_x_nx;
   logic [YW-1:0] addr_y_nx;
   logic [7:0]    data_nx;

   assign sum1 = 10'(r1) + 10'({g1, 1'b0}) + 10'(b1);

   // input registers, edge detection aligned with the stage-2 pixel, luma
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hd1      <= 1'b0;
         vd1      <= 1'b0;
         den1     <= 1'b0;
         r1       <= '0;
         g1       <= '0;
         b1       <= '0;
         hd2      <= 1'b0;
         vd2      <= 1'b0;
         den2     <= 1'b0;
         hd_fall  <= 1'b0;
         vd_fall  <= 1'b0;
         den_fall <= 1'b0;
         luma2    <= '0;
      end else begin
         hd1      <= i_HD;
         vd1      <= i_VD;
         den1     <= i_DEN;
         r1       <= i_R;
         g1       <= i_G;
         b1       <= i_B;
         hd2      <= hd1;
         vd2      <= vd1;
         den2     <= den1;
         hd_fall  <= hd2 & ~hd1;
         vd_fall  <= vd2 & ~vd1;
         den_fall <= den2 & ~den1;
         luma2    <= sum1[9:2];
      end
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   // next state, counter updates and write decision
   always_comb begin
      state_nx  = state;
      x_nx      = x;
      line_nx   = line;
      last_nx   = 1'b0;
      we_nx     = 1'b0;
      addr_x_nx = o_addrX;
      addr_y_nx = o_addrY;
      data_nx   = o_data;
      err_nx    = o_err;
      capturing = 1'b0;
      x_eff     = (hd_fall | den_fall | vd_fall) ? '0 : x;
      line_eff  = vd_fall ? '0 : line;

      unique case (state)
         IDLE: begin
            if (i_start) begin
               state_nx = WAIT_VS;
               err_nx   = 1'b0;
            end
         end
         WAIT_VS: begin
            if (vd_fall) begin
               state_nx  = CAPTURE;
               capturing = 1'b1;
            end
         end
         CAPTURE: begin
            if (last_wr) begin
               state_nx = DONE;
            end else begin
               capturing = 1'b1;
               if (vd_fall) err_nx = 1'b1;
            end
         end
         DONE: begin
            if (i_start) begin
               state_nx = WAIT_VS;
               err_nx   = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (capturing) begin
         x_nx    = x_eff;
         line_nx = line_eff;
         // end of a line: short line is an error, line still counts
         if (den_fall && !vd_fall) begin
            if (x < X_END) err_nx = 1'b1;
            if (line_eff < Y_END) line_nx = line_eff + YW'(1);
         end
         if (den2) begin
            if ((x_eff < X_END) && (line_eff < Y_END)) begin
               we_nx     = 1'b1;
               addr_x_nx = x_eff;
               addr_y_nx = FLIP_Y ? (Y_LAST - line_eff) : line_eff;
               data_nx   = luma2;
               x_nx      = x_eff + XW'(1);
               last_nx   = (x_eff == X_LAST) && (line_eff == Y_LAST);
            end else if (x_eff >= X_END) begin
               err_nx = 1'b1;
            end
         end
      end
   end

   // registered outputs and counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         x       <= '0;
         line    <= '0;
         last_wr <= 1'b0;
         o_we    <= 1'b0;
         o_addrX <= '0;
         o_addrY <= '0;
         o_data  <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         x       <= x_nx;
         line    <= line_nx;
         last_wr <= last_nx;
         o_we    <= we_nx;
         o_addrX <= addr_x_nx;
         o_addrY <= addr_y_nx;
         o_data  <= data_nx;
         o_busy  <= (state_nx == WAIT_VS) || (state_nx == CAPTURE);
         o_done  <= (state_nx == DONE);
         o_err   <= err_nx;
      end
   end

endmodule
